// File: rtl/reset_monitor_pkg.sv
// Shared constants for the target reset monitor and the reset generator that pairs with it.
// Keeps the FSM encodings and the default pulse/settle timing in one place.
package reset_monitor_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_LOW    = 2'd1;
    localparam state_t ST_SETTLE = 2'd2;

    // The generator drives pulses longer than DEF_MIN_PULSE so they always classify as valid.
    localparam int DEF_MIN_PULSE     = 1000;
    localparam int DEF_SETTLE_CYCLES = 100000;

endpackage

// File: rtl/reset_monitor_if.sv
// Bundle of the target reset line, the counter clear and every monitor result.
// master = the side observing results and driving clear; slave = the monitor itself.
interface reset_monitor_if #(
    parameter int CNT_W = 24,
    parameter int EVT_W = 16
);
    logic             target_rst_n;
    logic             clear;
    logic             in_reset;
    logic             pulse_done;
    logic             pulse_valid;
    logic [CNT_W-1:0] pulse_width;
    logic             glitch;
    logic             target_ready;
    logic [EVT_W-1:0] reset_count;
    logic [EVT_W-1:0] glitch_count;

    modport master (
        output target_rst_n, clear,
        input  in_reset, pulse_done, pulse_valid, pulse_width, glitch,
               target_ready, reset_count, glitch_count
    );

    modport slave (
        input  target_rst_n, clear,
        output in_reset, pulse_done, pulse_valid, pulse_width, glitch,
               target_ready, reset_count, glitch_count
    );
endinterface

// File: rtl/reset_monitor_bit_sync.sv
// N-flop single-bit synchronizer with a configurable reset value.
// Shared by every asynchronous input coming from the target.
module bit_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{RESET_VAL}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/reset_monitor.sv
// Measures low pulses on the target reset line, classifies them as reset or glitch,
// and strobes target_ready once a valid reset has been released for the settle window.
module reset_monitor
    import reset_monitor_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 24,
    parameter int MIN_PULSE     = DEF_MIN_PULSE,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int EVT_W         = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    reset_monitor_if.slave bus
);

    localparam logic [CNT_W-1:0] MIN_PULSE_C   = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] SETTLE_LAST_C = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX_C     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE_C     = CNT_W'(1);
    localparam logic [EVT_W-1:0] EVT_ONE_C     = EVT_W'(1);

    logic             sync_s;
    logic             sync_prev_r;
    logic             fall_s;
    logic             rise_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] width_r;
    logic [CNT_W-1:0] width_nxt_s;
    logic [CNT_W-1:0] settle_r;
    logic [CNT_W-1:0] settle_nxt_s;
    logic [CNT_W-1:0] pulse_width_r;
    logic [CNT_W-1:0] pulse_width_nxt_s;
    logic             in_reset_r;
    logic             in_reset_nxt_s;
    logic             pulse_done_r;
    logic             pulse_done_nxt_s;
    logic             pulse_valid_r;
    logic             pulse_valid_nxt_s;
    logic             glitch_r;
    logic             glitch_nxt_s;
    logic             ready_r;
    logic             ready_nxt_s;
    logic             reset_inc_s;
    logic             glitch_inc_s;
    logic [EVT_W-1:0] reset_count_r;
    logic [EVT_W-1:0] glitch_count_r;

    bit_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.target_rst_n),
        .q     (sync_s)
    );

    // Delayed copy of the synchronized line for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_prev_r <= 1'b1;
        end else begin
            sync_prev_r <= sync_s;
        end
    end

    assign fall_s = sync_prev_r & ~sync_s;
    assign rise_s = ~sync_prev_r & sync_s;

    // Next-state and next-output computation for the pulse/settle FSM.
    always_comb begin
        state_nxt_s       = state_r;
        width_nxt_s       = width_r;
        settle_nxt_s      = settle_r;
        pulse_width_nxt_s = pulse_width_r;
        in_reset_nxt_s    = in_reset_r;
        pulse_valid_nxt_s = pulse_valid_r;
        pulse_done_nxt_s  = 1'b0;
        glitch_nxt_s      = 1'b0;
        ready_nxt_s       = 1'b0;
        reset_inc_s       = 1'b0;
        glitch_inc_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (fall_s) begin
                    state_nxt_s    = ST_LOW;
                    width_nxt_s    = CNT_ONE_C;
                    in_reset_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOW: begin
                if (rise_s) begin
                    pulse_width_nxt_s = width_r;
                    pulse_done_nxt_s  = 1'b1;
                    in_reset_nxt_s    = 1'b0;
                    if (width_r >= MIN_PULSE_C) begin
                        pulse_valid_nxt_s = 1'b1;
                        reset_inc_s       = 1'b1;
                        settle_nxt_s      = {CNT_W{1'b0}};
                        state_nxt_s       = ST_SETTLE;
                    end else begin
                        pulse_valid_nxt_s = 1'b0;
                        glitch_nxt_s      = 1'b1;
                        glitch_inc_s      = 1'b1;
                        state_nxt_s       = ST_IDLE;
                    end
                end else if (!sync_s) begin
                    // Saturate rather than wrap so an overlong reset still reads as valid.
                    width_nxt_s = (width_r == CNT_MAX_C) ? width_r : width_r + CNT_ONE_C;
                end else begin
                    state_nxt_s = ST_LOW;
                end
            end
            ST_SETTLE: begin
                if (fall_s) begin
                    state_nxt_s    = ST_LOW;
                    width_nxt_s    = CNT_ONE_C;
                    in_reset_nxt_s = 1'b1;
                end else if (settle_r == SETTLE_LAST_C) begin
                    ready_nxt_s = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    settle_nxt_s = settle_r + CNT_ONE_C;
                end
            end
            default: begin
                state_nxt_s    = ST_IDLE;
                in_reset_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            width_r       <= {CNT_W{1'b0}};
            settle_r      <= {CNT_W{1'b0}};
            pulse_width_r <= {CNT_W{1'b0}};
            in_reset_r    <= 1'b0;
            pulse_done_r  <= 1'b0;
            pulse_valid_r <= 1'b0;
            glitch_r      <= 1'b0;
            ready_r       <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            width_r       <= width_nxt_s;
            settle_r      <= settle_nxt_s;
            pulse_width_r <= pulse_width_nxt_s;
            in_reset_r    <= in_reset_nxt_s;
            pulse_done_r  <= pulse_done_nxt_s;
            pulse_valid_r <= pulse_valid_nxt_s;
            glitch_r      <= glitch_nxt_s;
            ready_r       <= ready_nxt_s;
        end
    end

    // Event counters; an event landing on the clear cycle is kept as a count of one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reset_count_r  <= {EVT_W{1'b0}};
            glitch_count_r <= {EVT_W{1'b0}};
        end else begin
            if (bus.clear) begin
                reset_count_r  <= reset_inc_s ? EVT_ONE_C : {EVT_W{1'b0}};
                glitch_count_r <= glitch_inc_s ? EVT_ONE_C : {EVT_W{1'b0}};
            end else begin
                if (reset_inc_s) begin
                    reset_count_r <= reset_count_r + EVT_ONE_C;
                end
                if (glitch_inc_s) begin
                    glitch_count_r <= glitch_count_r + EVT_ONE_C;
                end
            end
        end
    end

    assign bus.in_reset     = in_reset_r;
    assign bus.pulse_done   = pulse_done_r;
    assign bus.pulse_valid  = pulse_valid_r;
    assign bus.pulse_width  = pulse_width_r;
    assign bus.glitch       = glitch_r;
    assign bus.target_ready = ready_r;
    assign bus.reset_count  = reset_count_r;
    assign bus.glitch_count = glitch_count_r;

endmodule

// File: tb/tb_reset_monitor.sv
// Directed bench for reset_monitor: a 24-bit instance for timing/classification
// and an 8-bit instance for width saturation.
module tb_reset_monitor;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    reset_monitor_if #(.CNT_W(24), .EVT_W(16)) bus_a ();
    reset_monitor_if #(.CNT_W(8),  .EVT_W(16)) bus_b ();

    reset_monitor #(
        .SYNC_STAGES(2), .CNT_W(24), .MIN_PULSE(1000), .SETTLE_CYCLES(200), .EVT_W(16)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );

    reset_monitor #(
        .SYNC_STAGES(2), .CNT_W(8), .MIN_PULSE(100), .SETTLE_CYCLES(200), .EVT_W(16)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    // Event recorder for instance A, sampled on the falling edge.
    int   cyc = 0;
    int   done_cyc_q[$];
    int   done_w_q[$];
    logic done_v_q[$];
    int   ready_cyc_q[$];
    int   glitch_n    = 0;
    int   in_reset_n  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus_a.pulse_done) begin
            done_cyc_q.push_back(cyc);
            done_w_q.push_back(int'(bus_a.pulse_width));
            done_v_q.push_back(bus_a.pulse_valid);
        end
        if (bus_a.target_ready) ready_cyc_q.push_back(cyc);
        if (bus_a.glitch) glitch_n = glitch_n + 1;
        if (bus_a.in_reset) in_reset_n = in_reset_n + 1;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic low_pulse_a(input int n);
        @(negedge clk);
        bus_a.target_rst_n = 1'b0;
        repeat (n) @(negedge clk);
        bus_a.target_rst_n = 1'b1;
    endtask

    task automatic pulse_clear;
        @(negedge clk);
        bus_a.clear = 1'b1;
        @(negedge clk);
        bus_a.clear = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        bus_a.target_rst_n = 1'b1;
        bus_a.clear        = 1'b0;
        bus_b.target_rst_n = 1'b1;
        bus_b.clear        = 1'b0;
        wait_cyc(4);
        n_checks++;
        if (bus_a.in_reset !== 1'b0 || bus_a.pulse_done !== 1'b0 || bus_a.glitch !== 1'b0 ||
            bus_a.target_ready !== 1'b0 || bus_a.pulse_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got in_reset=%b done=%b glitch=%b ready=%b valid=%b, expected all 0",
                     bus_a.in_reset, bus_a.pulse_done, bus_a.glitch, bus_a.target_ready, bus_a.pulse_valid);
        end
        n_checks++;
        if (bus_a.pulse_width !== 24'd0 || bus_a.reset_count !== 16'd0 || bus_a.glitch_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: got width=%0d rcnt=%0d gcnt=%0d, expected 0 0 0",
                     bus_a.pulse_width, bus_a.reset_count, bus_a.glitch_count);
        end
        rst_n = 1'b1;
        wait_cyc(5);
    endtask

    task automatic test_valid_pulse;
        int bd, br, bi;
        bd = done_cyc_q.size(); br = ready_cyc_q.size(); bi = in_reset_n;
        low_pulse_a(5000);
        wait_cyc(10);
        n_checks++;
        if (in_reset_n - bi !== 5000) begin
            n_fail++;
            $display("FAIL valid_in_reset_len: got %0d expected 5000", in_reset_n - bi);
        end
        n_checks++;
        if (done_cyc_q.size() - bd !== 1) begin
            n_fail++;
            $display("FAIL valid_done_count: got %0d expected 1", done_cyc_q.size() - bd);
        end else begin
            n_checks++;
            if (done_w_q[bd] !== 5000 || done_v_q[bd] !== 1'b1) begin
                n_fail++;
                $display("FAIL valid_width: got width=%0d valid=%b expected 5000 1", done_w_q[bd], done_v_q[bd]);
            end
        end
        n_checks++;
        if (bus_a.reset_count !== 16'd1) begin
            n_fail++;
            $display("FAIL valid_rcnt: got %0d expected 1", bus_a.reset_count);
        end
        wait_cyc(250);
        n_checks++;
        if (ready_cyc_q.size() - br !== 1) begin
            n_fail++;
            $display("FAIL valid_ready_count: got %0d expected 1", ready_cyc_q.size() - br);
        end else if (done_cyc_q.size() - bd == 1) begin
            n_checks++;
            if (ready_cyc_q[br] - done_cyc_q[bd] !== 200) begin
                n_fail++;
                $display("FAIL valid_ready_delay: got %0d expected 200", ready_cyc_q[br] - done_cyc_q[bd]);
            end
        end
    endtask

    task automatic test_glitch;
        int bd, br, bg;
        pulse_clear();
        bd = done_cyc_q.size(); br = ready_cyc_q.size(); bg = glitch_n;
        low_pulse_a(10);
        wait_cyc(10);
        n_checks++;
        if (done_cyc_q.size() - bd !== 1) begin
            n_fail++;
            $display("FAIL glitch_done_count: got %0d expected 1", done_cyc_q.size() - bd);
        end else begin
            n_checks++;
            if (done_w_q[bd] !== 10 || done_v_q[bd] !== 1'b0) begin
                n_fail++;
                $display("FAIL glitch_width: got width=%0d valid=%b expected 10 0", done_w_q[bd], done_v_q[bd]);
            end
        end
        n_checks++;
        if (glitch_n - bg !== 1 || bus_a.glitch_count !== 16'd1 || bus_a.reset_count !== 16'd0) begin
            n_fail++;
            $display("FAIL glitch_counts: got strobes=%0d gcnt=%0d rcnt=%0d expected 1 1 0",
                     glitch_n - bg, bus_a.glitch_count, bus_a.reset_count);
        end
        wait_cyc(250);
        n_checks++;
        if (ready_cyc_q.size() - br !== 0) begin
            n_fail++;
            $display("FAIL glitch_no_ready: got %0d ready strobes expected 0", ready_cyc_q.size() - br);
        end
    endtask

    task automatic test_boundary;
        int bd;
        pulse_clear();
        bd = done_cyc_q.size();
        low_pulse_a(999);
        wait_cyc(20);
        low_pulse_a(1000);
        wait_cyc(250);
        n_checks++;
        if (done_cyc_q.size() - bd !== 2) begin
            n_fail++;
            $display("FAIL boundary_done_count: got %0d expected 2", done_cyc_q.size() - bd);
        end else begin
            n_checks++;
            if (done_w_q[bd] !== 999 || done_v_q[bd] !== 1'b0 || done_w_q[bd+1] !== 1000 || done_v_q[bd+1] !== 1'b1) begin
                n_fail++;
                $display("FAIL boundary_class: got %0d/%b %0d/%b expected 999/0 1000/1",
                         done_w_q[bd], done_v_q[bd], done_w_q[bd+1], done_v_q[bd+1]);
            end
        end
        n_checks++;
        if (bus_a.glitch_count !== 16'd1 || bus_a.reset_count !== 16'd1) begin
            n_fail++;
            $display("FAIL boundary_counts: got gcnt=%0d rcnt=%0d expected 1 1", bus_a.glitch_count, bus_a.reset_count);
        end
    endtask

    task automatic test_settle_abort;
        int bd, br;
        pulse_clear();
        bd = done_cyc_q.size(); br = ready_cyc_q.size();
        low_pulse_a(2000);
        wait_cyc(48);
        low_pulse_a(3000);
        wait_cyc(250);
        n_checks++;
        if (done_cyc_q.size() - bd !== 2) begin
            n_fail++;
            $display("FAIL abort_done_count: got %0d expected 2", done_cyc_q.size() - bd);
        end else begin
            n_checks++;
            if (done_w_q[bd] !== 2000 || done_w_q[bd+1] !== 3000 || done_v_q[bd+1] !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_widths: got %0d %0d/%b expected 2000 3000/1",
                         done_w_q[bd], done_w_q[bd+1], done_v_q[bd+1]);
            end
            n_checks++;
            if (ready_cyc_q.size() - br !== 1) begin
                n_fail++;
                $display("FAIL abort_ready_count: got %0d expected 1", ready_cyc_q.size() - br);
            end else begin
                n_checks++;
                if (ready_cyc_q[br] - done_cyc_q[bd+1] !== 200) begin
                    n_fail++;
                    $display("FAIL abort_ready_delay: got %0d expected 200", ready_cyc_q[br] - done_cyc_q[bd+1]);
                end
            end
        end
        n_checks++;
        if (bus_a.reset_count !== 16'd2) begin
            n_fail++;
            $display("FAIL abort_rcnt: got %0d expected 2", bus_a.reset_count);
        end
    endtask

    task automatic test_saturation;
        @(negedge clk);
        bus_b.target_rst_n = 1'b0;
        wait_cyc(400);
        bus_b.target_rst_n = 1'b1;
        wait_cyc(10);
        n_checks++;
        if (bus_b.pulse_width !== 8'd255 || bus_b.pulse_valid !== 1'b1 || bus_b.reset_count !== 16'd1) begin
            n_fail++;
            $display("FAIL saturation: got width=%0d valid=%b rcnt=%0d expected 255 1 1",
                     bus_b.pulse_width, bus_b.pulse_valid, bus_b.reset_count);
        end
        wait_cyc(250);
    endtask

    task automatic test_reset_mid_pulse;
        int bd;
        bd = done_cyc_q.size();
        @(negedge clk);
        bus_a.target_rst_n = 1'b0;
        wait_cyc(300);
        rst_n = 1'b0;
        wait_cyc(3);
        n_checks++;
        if (bus_a.in_reset !== 1'b0 || bus_a.pulse_width !== 24'd0 || bus_a.pulse_valid !== 1'b0 ||
            bus_a.reset_count !== 16'd0) begin
            n_fail++;
            $display("FAIL midrst_values: got in_reset=%b width=%0d valid=%b rcnt=%0d expected 0 0 0 0",
                     bus_a.in_reset, bus_a.pulse_width, bus_a.pulse_valid, bus_a.reset_count);
        end
        rst_n = 1'b1;
        wait_cyc(1200);
        bus_a.target_rst_n = 1'b1;
        wait_cyc(10);
        n_checks++;
        if (done_cyc_q.size() - bd !== 1) begin
            n_fail++;
            $display("FAIL midrst_done_count: got %0d expected 1", done_cyc_q.size() - bd);
        end else begin
            n_checks++;
            if (done_w_q[bd] !== 1200 || done_v_q[bd] !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_width: got %0d/%b expected 1200/1", done_w_q[bd], done_v_q[bd]);
            end
        end
        wait_cyc(250);
    endtask

    task automatic test_clear_coincide;
        low_pulse_a(10);
        wait_cyc(20);
        n_checks++;
        if (bus_a.glitch_count !== 16'd1 || bus_a.reset_count !== 16'd1) begin
            n_fail++;
            $display("FAIL clr_pre_counts: got gcnt=%0d rcnt=%0d expected 1 1", bus_a.glitch_count, bus_a.reset_count);
        end
        low_pulse_a(1500);
        // The increment lands on the third rising edge after the pin goes high.
        wait_cyc(2);
        bus_a.clear = 1'b1;
        @(negedge clk);
        bus_a.clear = 1'b0;
        n_checks++;
        if (bus_a.pulse_done !== 1'b1 || bus_a.reset_count !== 16'd1 || bus_a.glitch_count !== 16'd0) begin
            n_fail++;
            $display("FAIL clr_coincide: got done=%b rcnt=%0d gcnt=%0d expected 1 1 0",
                     bus_a.pulse_done, bus_a.reset_count, bus_a.glitch_count);
        end
        wait_cyc(250);
    endtask

    initial begin
        test_reset();
        test_valid_pulse();
        test_glitch();
        test_boundary();
        test_settle_abort();
        test_saturation();
        test_reset_mid_pulse();
        test_clear_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
